// File: rtl/lp_serializer_pkg.sv
// Shared types and constants for the serializer scheduler: state encoding,
// word width and the tree-order bit permutation feeding the serializer.
package lp_serializer_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_e;

  // Output bit k of the permuted word takes input bit PERM[k].
  localparam logic [3:0] PERM [WORD_W] = '{
    4'd1, 4'd9, 4'd13, 4'd5, 4'd7, 4'd15, 4'd3, 4'd11,
    4'd4, 4'd12, 4'd0, 4'd8, 4'd10, 4'd2, 4'd6, 4'd14
  };

  function automatic logic [WORD_W-1:0] permute(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int k = 0; k < WORD_W; k++) begin
      r[k] = w[PERM[k]];
    end
    return r;
  endfunction

endpackage

// File: rtl/lp_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or above rr_ptr,
// wrapping around; returns one-hot grant, its index and an any-valid flag.
module lp_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((int'(rr_ptr_i) + off) % NUM_REQ);
      if (!any_o && valid_i[cand]) begin
        any_o         = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lp_serializer_sched.sv
// Round-robin front end for the tree serializer: grants one word, holds it
// permuted on par_out_o for RUN_CYCLES, then drives zero for CLEAR_CYCLES.
module lp_serializer_sched
  import lp_serializer_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int RUN_CYCLES   = 21,
  parameter  int CLEAR_CYCLES = 7,
  localparam int IDX_W        = $clog2(NUM_REQ),
  localparam int CNT_MAX      = (RUN_CYCLES > CLEAR_CYCLES) ? RUN_CYCLES : CLEAR_CYCLES,
  localparam int CNT_W        = $clog2(CNT_MAX + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [WORD_W*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic                      hold_i,
  output logic [WORD_W-1:0]         par_out_o,
  output logic                      frame_start_o,
  output logic                      frame_done_o,
  output logic [IDX_W-1:0]          grant_id_o,
  output logic                      busy_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  par_q, par_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gid_q, gid_d;
  logic               start_q, start_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               grant_ok;

  lp_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid_i  (req_valid_i),
    .rr_ptr_i (ptr_q),
    .grant_o  (arb_grant),
    .idx_o    (arb_idx),
    .any_o    (arb_any)
  );

  // The accept strobe is the only combinational output: zero-latency grant.
  assign grant_ok    = (state_q == IDLE) && !hold_i && arb_any;
  assign req_ready_o = grant_ok ? arb_grant : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_ok) begin
          state_d = RUN;
          cnt_d   = CNT_W'(RUN_CYCLES - 1);
          par_d   = permute(req_data_i[arb_idx*WORD_W +: WORD_W]);
          gid_d   = arb_idx;
          ptr_d   = IDX_W'((int'(arb_idx) + 1) % NUM_REQ);
          start_d = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = CLEAR;
          cnt_d   = CNT_W'(CLEAR_CYCLES - 1);
          par_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CLEAR: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        par_d   = '0;
      end
    endcase
    // Done marks the final CLEAR cycle, so it is registered one cycle ahead.
    done_d = (state_d == CLEAR) && (cnt_d == '0);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      par_q   <= '0;
      ptr_q   <= '0;
      gid_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      start_q <= start_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign par_out_o     = par_q;
  assign frame_start_o = start_q;
  assign frame_done_o  = done_q;
  assign grant_id_o    = gid_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_lp_serializer_sched.sv
// Randomized bench with a frame-timing reference model and a word scoreboard
// that inverts the permutation on each frame to recover the transmitted word.
module tb_lp_serializer_sched;

  localparam int NR     = 4;
  localparam int RUNC   = 21;
  localparam int CLRC   = 7;
  localparam int PERIOD = RUNC + CLRC + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [16*NR-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic            hold = 1'b0;
  logic [15:0]     par_out;
  logic            frame_start, frame_done, busy;
  logic [1:0]      grant_id;

  always #5 clk = ~clk;

  lp_serializer_sched #(.NUM_REQ(NR), .RUN_CYCLES(RUNC), .CLEAR_CYCLES(CLRC)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_data_i    (req_data),
    .req_ready_o   (req_ready),
    .hold_i        (hold),
    .par_out_o     (par_out),
    .frame_start_o (frame_start),
    .frame_done_o  (frame_done),
    .grant_id_o    (grant_id),
    .busy_o        (busy)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int TP [16] = '{1, 9, 13, 5, 7, 15, 3, 11, 4, 12, 0, 8, 10, 2, 6, 14};

  function automatic logic [15:0] ref_perm(input logic [15:0] w);
    logic [15:0] r = '0;
    for (int k = 0; k < 16; k++) r[k] = w[TP[k]];
    return r;
  endfunction

  function automatic logic [15:0] ref_unperm(input logic [15:0] p);
    logic [15:0] r = '0;
    for (int k = 0; k < 16; k++) r[TP[k]] = p[k];
    return r;
  endfunction

  // Per-requester word queues drained by handshakes.
  logic [15:0] wbuf [NR][64];
  int          head [NR];
  int          tail [NR];
  logic        drop_en = 1'b0;
  logic [NR-1:0] hs_q = '0;

  task automatic push(input int id, input logic [15:0] w);
    wbuf[id][tail[id]] = w;
    tail[id]++;
  endtask

  always begin
    @(posedge clk);
    #2;
    for (int i = 0; i < NR; i++) if (hs_q[i]) head[i]++;
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (head[i] < tail[i]) && (!drop_en || ($urandom_range(0, 3) != 0));
      req_data[i*16 +: 16] = (head[i] < tail[i]) ? wbuf[i][head[i]] : 16'h0;
    end
  end

  // Reference model: frame timing from the grant cycle, round-robin pointer.
  int          cyc = 0;
  int          m_ptr = 0, m_gcyc = 0, m_gid = 0;
  logic [15:0] m_word = '0;
  bit          m_active = 1'b0;
  logic [15:0] e_word [256];
  logic [15:0] o_word [256];
  int          o_cyc  [256];
  int          e_n = 0, o_n = 0;
  int          off, g, j;
  bit          in_run, in_clr;
  logic [NR-1:0] x_ready;

  always @(posedge clk) cyc++;

  function automatic bit model_busy();
    return m_active && ((cyc - m_gcyc) < RUNC + CLRC);
  endfunction

  always @(negedge clk) begin
    hs_q = req_ready & req_valid & {NR{rst_n}};
    if (!rst_n) begin
      m_active = 1'b0;
      m_ptr    = 0;
      m_gid    = 0;
      check("rst_par", par_out, 0);
      check("rst_busy", busy, 0);
      check("rst_start", frame_start, 0);
      check("rst_done", frame_done, 0);
      check("rst_gid", grant_id, 0);
    end else begin
      off    = cyc - m_gcyc;
      in_run = m_active && (off < RUNC);
      in_clr = m_active && (off >= RUNC) && (off < RUNC + CLRC);
      x_ready = '0;
      g = -1;
      if (!(in_run || in_clr) && !hold) begin
        for (int k = 0; k < NR; k++) begin
          j = (m_ptr + k) % NR;
          if (g < 0 && req_valid[j]) g = j;
        end
      end
      if (g >= 0) x_ready[g] = 1'b1;
      check("ready", req_ready, x_ready);
      check("par_out", par_out, in_run ? ref_perm(m_word) : 16'h0);
      check("busy", busy, in_run || in_clr);
      check("frame_start", frame_start, m_active && (off == 0));
      check("frame_done", frame_done, m_active && (off == RUNC + CLRC - 1));
      check("grant_id", grant_id, m_gid);
      if (frame_start) begin
        o_word[o_n] = ref_unperm(par_out);
        o_cyc[o_n]  = cyc;
        o_n++;
      end
      if (g >= 0) begin
        m_active = 1'b1;
        m_gcyc   = cyc + 1;
        m_gid    = g;
        m_word   = req_data[g*16 +: 16];
        m_ptr    = (g + 1) % NR;
        e_word[e_n] = m_word;
        e_n++;
      end
    end
  end

  function automatic bit queues_empty();
    for (int i = 0; i < NR; i++) if (head[i] < tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (!(queues_empty() && !model_busy()) && n < budget) begin
      @(posedge clk);
      #3;
      n++;
    end
    if (n >= budget) check("drain_timeout", 0, 1);
  endtask

  task automatic wait_busy(input int budget);
    int n = 0;
    while (!model_busy() && n < budget) begin
      @(posedge clk);
      #3;
      n++;
    end
    if (n >= budget) check("busy_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  logic [15:0] rr_words [5] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0001};
  int base, total;

  initial begin
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Single frame from requester 0.
    push(0, 16'hC5AF);
    drain(200);
    check("single_count", o_n, 1);
    check("single_word", o_word[0], 16'hC5AF);

    // Pointer wrap: after a grant to 2, requester 3 beats requester 1.
    base = o_n;
    push(2, 16'h2222);
    wait_busy(50);
    push(3, 16'h3333);
    push(1, 16'h1111);
    drain(300);
    check("wrap_0", o_word[base], 16'h2222);
    check("wrap_1", o_word[base+1], 16'h3333);
    check("wrap_2", o_word[base+2], 16'h1111);

    // Round robin from a fresh pointer with all requesters busy.
    do_reset();
    base = o_n;
    for (int i = 0; i < NR; i++) push(i, rr_words[i]);
    push(0, rr_words[4]);
    drain(400);
    for (int k = 0; k < 5; k++) check("rr_word", o_word[base+k], rr_words[k]);
    for (int k = 1; k < 5; k++) check("rr_period", o_cyc[base+k] - o_cyc[base+k-1], PERIOD);

    // HOLD asserted mid-RUN lets the frame finish, then blocks grants.
    base = o_n;
    push(0, 16'hBEEF);
    wait_busy(50);
    repeat (5) @(posedge clk);
    #2 hold = 1'b1;
    push(1, 16'h1234);
    repeat (40) @(posedge clk);
    #3;
    check("hold_busy", busy, 0);
    check("hold_ready", req_ready, 0);
    check("hold_frames", o_n - base, 1);
    @(posedge clk);
    #2 hold = 1'b0;
    #1 check("hold_release_ready", req_ready, 4'b0010);
    drain(200);
    check("hold_word0", o_word[base], 16'hBEEF);
    check("hold_word1", o_word[base+1], 16'h1234);

    // Asynchronous reset in the middle of RUN.
    do_reset();
    for (int i = 0; i < NR; i++) begin
      push(i, 16'hA000 | 16'(i << 4));
      push(i, 16'hA001 | 16'(i << 4));
    end
    wait_busy(50);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_par", par_out, 0);
    check("arst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    base = o_n;
    drain(600);
    check("arst_first", o_word[base], 16'hA001);

    // Random words, requesters and VALID drops.
    drop_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      push($urandom_range(0, NR - 1), 16'($urandom));
      repeat ($urandom_range(0, 30)) @(posedge clk);
      #3;
    end
    drain(3000);
    drop_en = 1'b0;

    // Every pushed word accepted once and transmitted in grant order.
    total = 0;
    for (int i = 0; i < NR; i++) total += tail[i];
    check("accepted_all", e_n, total);
    check("frame_count", o_n, e_n);
    for (int i = 0; i < e_n && i < o_n; i++) check("frame_word", o_word[i], e_word[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/lp_serializer_sched.md
# lp_serializer_sched

Round-robin scheduler that shares one lp_tree_serializer between NUM_REQ word producers. It accepts 16-bit words over valid/ready and drives the serializer's parallel input with a tree-order permutation. Each word is held for a RUN window and followed by an all-zero CLEAR window so the serializer pipeline drains between frames. It sits directly in front of the serializer's PAR_IN and is the only driver of that bus.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- RUN_CYCLES, 21: cycles a word is held on PAR_OUT (≥1)
- CLEAR_CYCLES, 7: cycles of zero word after each frame (≥1)
- CLK  in  1  clock
- RESET  in  1  reset, asynchronous, active-low
- REQ_VALID  in  NUM_REQ  per-requester word valid
- REQ_DATA  in  16*NUM_REQ  requester i word at bits [16i+15:16i], logical bit order
- REQ_READY  out  NUM_REQ  one-hot accept strobe; transfer when VALID&READY at posedge
- HOLD  in  1  when high, no new grant is issued; the frame in progress completes
- PAR_OUT  out  16  to serializer PAR_IN, permuted word or zero
- FRAME_START  out  1  one-cycle pulse, first cycle of RUN
- FRAME_DONE  out  1  one-cycle pulse, last cycle of CLEAR
- GRANT_ID  out  $clog2(NUM_REQ)  requester of current/last frame
- BUSY  out  1  high in RUN or CLEAR

## Operation
- States: IDLE, RUN, CLEAR.
- IDLE: if !HOLD and any REQ_VALID, grant the first valid requester searching from rr_ptr upward with wrap.
  - REQ_READY[g] is combinational: high only in IDLE, only for g.
  - At that edge: capture the permuted word into PAR_OUT, load GRANT_ID=g, set rr_ptr=(g+1) mod NUM_REQ, enter RUN.
- RUN: PAR_OUT stays constant for RUN_CYCLES cycles, then the state goes to CLEAR and PAR_OUT becomes 0.
- CLEAR: PAR_OUT=0 for CLEAR_CYCLES cycles, then IDLE.
- A single down-counter is shared by RUN and CLEAR.
  - Width is $clog2(max(RUN_CYCLES,CLEAR_CYCLES)+1).
  - Loaded with N-1 on entry; the state transitions when it reads 0.
- Permutation. PAR_OUT[k] = word[P[k]], with P = {1,9,13,5,7,15,3,11,4,12,0,8,10,2,6,14} for k=0..15.
- REQ_VALID is ignored in RUN and CLEAR. Requesters may drop VALID before being granted, with no penalty.
- HOLD is sampled only in IDLE. Asserting HOLD during RUN or CLEAR does not truncate the frame.
- Reset (asynchronous, any state):
  - State = IDLE, PAR_OUT = 0, counter = 0, rr_ptr = 0, GRANT_ID = 0.
  - REQ_READY, FRAME_START, FRAME_DONE and BUSY all go low.
  - A frame interrupted by reset is dropped, not replayed.

## Timing
- Grant edge T0: PAR_OUT carries the word during cycles T0+1..T0+RUN_CYCLES. FRAME_START is high in cycle T0+1.
- Zero word during the next CLEAR_CYCLES cycles. FRAME_DONE is high in the last of these cycles.
- IDLE for at least one cycle before the next grant. Minimum frame period = RUN_CYCLES+CLEAR_CYCLES+1 (29 with defaults).
- Zero latency from VALID to READY when IDLE and not HOLD.
- All outputs except REQ_READY are registered.
- After RESET deasserts, the first grant is possible at the first posedge.

## Structure
- Package lp_serializer_pkg holds:
  - the permutation constant P (16 × 4-bit array);
  - the state enum {IDLE, RUN, CLEAR};
  - the word width constant 16.
- Sub-module lp_rr_arbiter (NUM_REQ): inputs valid and rr_ptr, outputs one-hot grant and index. Purely combinational.
- Total RTL 150–250 lines.

## Test plan
- Single frame:
  - Stimulus: req0 word 16'hC5AF, HOLD=0.
  - Response: READY[0] for one cycle; PAR_OUT = permute(16'hC5AF) for 21 cycles, then 0 for 7 cycles.
  - Check: FRAME_START and FRAME_DONE pulses; serializer SERIAL_OUT matches the golden bit stream.
- Round robin:
  - Stimulus: all 4 requesters valid continuously with words 16'h0001, 16'h0002, 16'h0004, 16'h0008.
  - Response: grants in order 0,1,2,3,0; grant edges 29 cycles apart; GRANT_ID tracks each grant.
- Pointer wrap:
  - Stimulus: only req3 then req1 valid, after a grant to req2.
  - Response: req3 is granted before req1.
- HOLD:
  - Stimulus: assert HOLD mid-RUN.
  - Response: the current frame completes. While HOLD stays high, no READY fires and the block stays in IDLE. Deasserting HOLD produces a grant in the same cycle.
- Reset mid-RUN:
  - Stimulus: drop RESET asynchronously, between clock edges.
  - Response: PAR_OUT = 0 and BUSY = 0 immediately. After release, rr_ptr = 0, so req0 wins a 4-way tie.
- Random:
  - Stimulus: 10 random words from random requesters with random VALID drop.
  - Response: each accepted word appears exactly once on SERIAL_OUT in grant order. No word is lost or duplicated.
